vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM (3-bit RGB per pixel, 640x480) between two requesters:
  - the VGA scan-out path, which pulls pixels with fetch_next_pixel;
  - a host writer, which stores pixels through a valid/ready handshake.
- Display reads are prefetched into a small FIFO and have priority, so the pixel stream never starves during active video.
- Host writes use the leftover RAM slots, mostly during blanking.
- Sits between vga_driver (i_pixel_r/g/b, o_fetch_next_pixel) and the framebuffer RAM, in the pixel clock domain.

Parameters:
- H_PIXELS, 640, visible pixels per line
- V_LINES, 480, visible lines per frame
- ADDR_W, 19, framebuffer address width; must hold H_PIXELS*V_LINES-1
- FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, minimum 2)
- LOW_WATER, 2, FIFO occupancy (level+inflight) below which a display read beats a host write
- UNDERFLOW_RGB, 3'd0, colour driven when the FIFO is empty

Ports:
- clk, in, 1, pixel clock (25 MHz)
- reset_, in, 1, asynchronous active-low reset
- i_frame_start, in, 1, one-cycle pulse: restart scan-out at pixel 0
- i_fetch_next_pixel, in, 1, pops one pixel from the FIFO
- o_pixel_rgb, out, 3, FIFO head pixel {r,g,b}
- o_underflow, out, 1, sticky: a fetch occurred while the FIFO was empty
- i_wr_valid, in, 1, host write request
- i_wr_addr, in, ADDR_W, host pixel address (y*H_PIXELS+x)
- i_wr_data, in, 3, host pixel value
- o_wr_ready, out, 1, host write accepted this cycle
- o_mem_en, out, 1, RAM access strobe
- o_mem_we, out, 1, RAM write enable
- o_mem_addr, out, ADDR_W, RAM address
- o_mem_wdata, out, 3, RAM write data
- i_mem_rdata, in, 3, RAM read data, valid one cycle after en&!we

Behaviour:
- Reset (async assert, sync release):
  - state ST_FLUSH; rd_addr=0; FIFO empty; inflight=0.
  - o_mem_en=0, o_mem_we=0, o_wr_ready=0, o_underflow=0, o_pixel_rgb=UNDERFLOW_RGB.
- State machine:
  - ST_FLUSH: one cycle. Clears the FIFO, rd_addr, inflight and o_underflow. Next state ST_STREAM. No display reads; host writes may be granted.
  - ST_STREAM: issues display reads. The read that uses address H_PIXELS*V_LINES-1 moves the state to ST_DONE.
  - ST_DONE: no display reads. Host is granted every cycle it is valid. The FIFO keeps draining.
  - i_frame_start from any state moves to ST_FLUSH next cycle. In that cycle: no grants, o_mem_en=0, o_wr_ready=0, and the read data of any inflight read is discarded.
- Slot arbitration, one RAM access per cycle, evaluated combinationally:
  - occ = level + inflight.
  - rd_req = (state==ST_STREAM) & (occ<FIFO_DEPTH). When a pop occurs in the same cycle, the threshold uses occ-1.
  - Display read is granted if rd_req & (occ<LOW_WATER | !i_wr_valid).
  - Otherwise o_wr_ready = i_wr_valid.
  - o_wr_ready may depend on i_wr_valid. The host must hold valid, addr and data stable until ready.
- Host writes:
  - Accepted write with i_wr_addr < H_PIXELS*V_LINES: o_mem_en=1, o_mem_we=1, addr/wdata passed through the same cycle.
  - Out-of-range address: handshake completes (ready=1), no RAM access.
- Display reads:
  - Granted read drives o_mem_en=1, o_mem_we=0, o_mem_addr=rd_addr; rd_addr increments and inflight is set.
  - Next cycle i_mem_rdata is pushed into the FIFO.
  - The first pixel is available 3 cycles after i_frame_start (FLUSH, issue, push).
- Pixel output:
  - o_pixel_rgb = FIFO head, or UNDERFLOW_RGB when the FIFO is empty.
  - i_fetch_next_pixel pops the head. Push and pop in the same cycle are legal; level is unchanged.
  - Fetch while empty: no pop, o_underflow is set and held until the next ST_FLUSH.
  - Fetches in ST_DONE after the FIFO drains count as underflow.
- Widths: rd_addr compares against the constant H_PIXELS*V_LINES computed at ADDR_W. Level counter is clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package vga_pkg:
  - H_PIXELS/V_LINES defaults and FB_PIXELS = H_PIXELS*V_LINES.
  - The 3-bit rgb type.
  - State encodings ST_FLUSH=2'd0, ST_STREAM=2'd1, ST_DONE=2'd2.
- One sub-module, pixel_fifo: synchronous FIFO, parameter DEPTH, width 3, with push/pop/level/empty/full and a clear input driven in ST_FLUSH.
- Arbiter, FSM and address counter stay in the top module.

Test Plan:
- Reset, then i_frame_start with a RAM model preloaded addr[2:0] → first mem read at addr 0 two cycles after the pulse; o_pixel_rgb=3'd0 (addr 0) 3 cycles after the pulse; then 4 outstanding reads fill the FIFO and o_mem_en stops.
- Continuous i_fetch_next_pixel for 640 cycles after the FIFO fills → pixels equal addr[2:0] in order 0..639, o_underflow stays 0, no host grants while occ<LOW_WATER.
- i_wr_valid held with addr=1000, data=3'b101, FIFO full, no fetch → o_wr_ready=1 the same cycle, o_mem_we=1, o_mem_addr=1000, o_mem_wdata=3'b101.
- i_wr_valid with addr=307200 (out of range) → ready=1, o_mem_en=0.
- Fetch pulsed at cycle 1 after i_frame_start (FIFO empty) → o_underflow=1, o_pixel_rgb=UNDERFLOW_RGB; o_underflow clears one cycle after the next i_frame_start.
- Run to pixel 307199 → state ST_DONE, no further reads, a host write in every valid cycle. i_frame_start asserted together with i_wr_valid → ready=0 that cycle; scan-out restarts at addr 0.
- Assert reset_ mid-stream with inflight=1 → all outputs immediately return to their reset values; on release, no FIFO push from the stale read.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared framebuffer/VGA definitions: default geometry, pixel type, scan-out states.
package vga_pkg;

  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_LINES  = 480;
  localparam int FB_PIXELS    = DEF_H_PIXELS * DEF_V_LINES;

  // One framebuffer pixel, packed {r,g,b}.
  typedef logic [2:0] rgb_t;

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous prefetch FIFO for display pixels; clear empties it in one cycle.
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   clear,
  input  logic                   push,
  input  rgb_t                   din,
  input  logic                   pop,
  output rgb_t                   dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  rgb_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == LW'(0));
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear wins over a simultaneous push/pop.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Pixel storage, data only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: prefetching display reads take priority over host writes.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int         H_PIXELS      = DEF_H_PIXELS,
  parameter int         V_LINES       = DEF_V_LINES,
  parameter int         ADDR_W        = $clog2(FB_PIXELS),
  parameter int         FIFO_DEPTH    = 4,
  parameter int         LOW_WATER     = 2,
  parameter logic [2:0] UNDERFLOW_RGB = 3'd0
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              i_frame_start,
  input  logic              i_fetch_next_pixel,
  output logic [2:0]        o_pixel_rgb,
  output logic              o_underflow,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [2:0]        i_wr_data,
  output logic              o_wr_ready,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [2:0]        o_mem_wdata,
  input  logic [2:0]        i_mem_rdata
);

  localparam int                LW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] FB_PIX  = ADDR_W'(H_PIXELS * V_LINES);
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(H_PIXELS * V_LINES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_vld_p1;
  logic [LW-1:0]     level;
  logic [LW-1:0]     occ;
  logic [LW-1:0]     occ_eff;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              flush;
  logic              gate;
  logic              rd_req;
  logic              rd_grant;
  logic              wr_in_range;
  rgb_t              head;

  assign flush       = (state == ST_FLUSH);
  assign pop         = i_fetch_next_pixel & ~fifo_empty;
  // Read data returning in a restart cycle belongs to the old frame and is dropped.
  assign push        = rd_vld_p1 & ~i_frame_start;
  assign o_pixel_rgb = fifo_empty ? UNDERFLOW_RGB : head;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_ (reset_),
    .clear  (flush),
    .push   (push),
    .din    (rgb_t'(i_mem_rdata)),
    .pop    (pop),
    .dout   (head),
    .level  (level),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Slot arbitration: display reads win while the prefetch is running low or the host is idle.
  always_comb begin
    occ         = level + LW'(rd_vld_p1);
    occ_eff     = occ - LW'(pop);
    gate        = reset_ & ~i_frame_start;
    rd_req      = (state == ST_STREAM) && (occ_eff < LW'(FIFO_DEPTH)) && !(fifo_full && !pop);
    rd_grant    = gate & rd_req & ((occ_eff < LW'(LOW_WATER)) | ~i_wr_valid);
    o_wr_ready  = gate & i_wr_valid & ~rd_grant;
    wr_in_range = (i_wr_addr < FB_PIX);
    o_mem_we    = o_wr_ready & wr_in_range;
    o_mem_en    = rd_grant | o_mem_we;
    o_mem_addr  = rd_grant ? rd_addr : i_wr_addr;
    o_mem_wdata = i_wr_data;
  end

  // Next-state logic; a frame restart overrides every state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FLUSH:  state_nxt = ST_STREAM;
      ST_STREAM: if (rd_grant && (rd_addr == FB_LAST)) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_DONE;
      default:   state_nxt = ST_FLUSH;
    endcase
    if (i_frame_start) state_nxt = ST_FLUSH;
  end

  // State, scan address, read-in-flight flag and sticky underflow.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= ST_FLUSH;
      rd_addr     <= '0;
      rd_vld_p1   <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_vld_p1 <= rd_grant;
      if (flush)         rd_addr <= '0;
      else if (rd_grant) rd_addr <= rd_addr + ADDR_W'(1);
      // A fetch on an empty FIFO during flush still counts for the new frame.
      o_underflow <= (o_underflow & ~flush) | (i_fetch_next_pixel & fifo_empty);
    end
  end

endmodule
